// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: walks the datapath through fetch (T0-T2) and
// opcode-specific execute steps (T3-T7), with memory handshake waits and timeout.
module control_sequencer #(
  parameter int OPW      = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [OPW-1:0] ir_op,
  input  logic           con_ff,
  input  logic           mem_ready,
  input  logic           stop,
  output logic           PCout,
  output logic           IncPC,
  output logic           PCin,
  output logic           MARin,
  output logic           MDRin,
  output logic           MDRout,
  output logic           Read,
  output logic           Write,
  output logic           IRin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           RCout,
  output logic           Yin,
  output logic           ZLowIn,
  output logic           ZLowOut,
  output logic           CONin,
  output logic           InPortout,
  output logic           OutPortIn,
  output logic [3:0]     alu_op,
  output logic           run,
  output logic           err_illegal,
  output logic           err_timeout,
  output logic [3:0]     step
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  localparam logic [OPW-1:0] OP_LD   = OPW'(0),  OP_LDI  = OPW'(1),  OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3),  OP_SUB  = OPW'(4),  OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6),  OP_ADDI = OPW'(7),  OP_ANDI = OPW'(8);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(9),  OP_BR   = OPW'(10), OP_JR   = OPW'(11);
  localparam logic [OPW-1:0] OP_IN   = OPW'(12), OP_OUT  = OPW'(13), OP_HALT = OPW'(15);

  // Step encoding doubles as the debug value; PAUSE reports as F like IDLE.
  typedef enum logic [3:0] {
    S_T0 = 4'h0, S_T1 = 4'h1, S_T2 = 4'h2, S_T3 = 4'h3,
    S_T4 = 4'h4, S_T5 = 4'h5, S_T6 = 4'h6, S_T7 = 4'h7,
    S_PAUSE = 4'hD, S_HALT = 4'hE, S_IDLE = 4'hF
  } state_t;

  state_t        state_reg, state_next, entry_state;
  logic [CW-1:0] wait_cnt_reg;
  logic          op_alu, op_imm, op_addr, legal, is_wait, timeout_hit;

  assign op_alu  = ir_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign op_imm  = ir_op inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign op_addr = ir_op inside {OP_LDI, OP_LD, OP_ST};
  assign legal   = (ir_op <= OP_HALT);

  assign entry_state = stop ? S_PAUSE : S_T0;
  assign is_wait     = (state_reg == S_T1) ||
                       (state_reg == S_T6 && ir_op == OP_LD) ||
                       (state_reg == S_T7 && ir_op == OP_ST);
  // A mem_ready on the final allowed cycle still completes the step.
  assign timeout_hit = is_wait && !mem_ready && (wait_cnt_reg == CW'(MAX_WAIT - 1));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      err_timeout  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (is_wait && !mem_ready && !timeout_hit) wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else                                       wait_cnt_reg <= '0;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  state_next = entry_state;
      S_PAUSE: if (!stop) state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    if (mem_ready) state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3: begin
        if (ir_op == OP_HALT)                              state_next = S_HALT;
        else if (op_alu || op_imm || op_addr || ir_op == OP_BR) state_next = S_T4;
        else                                               state_next = entry_state;
      end
      S_T4:    state_next = S_T5;
      S_T5:    state_next = (ir_op inside {OP_LD, OP_ST, OP_BR}) ? S_T6 : entry_state;
      S_T6: begin
        if (ir_op == OP_LD)      state_next = mem_ready ? S_T7 : S_T6;
        else if (ir_op == OP_ST) state_next = S_T7;
        else                     state_next = entry_state;
      end
      S_T7:    state_next = (ir_op == OP_ST && !mem_ready) ? S_T7 : entry_state;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
    if (timeout_hit) state_next = S_HALT;
  end

  always_comb begin
    {PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, Write, IRin} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, RCout, Yin, ZLowIn, ZLowOut, CONin} = '0;
    {InPortout, OutPortIn, err_illegal} = '0;
    alu_op = 4'b0000;
    run    = !(state_reg == S_HALT || state_reg == S_PAUSE);
    step   = (state_reg == S_PAUSE) ? 4'hF : state_reg;
    case (state_reg)
      S_T0: {PCout, MARin, IncPC, PCin} = 4'b1111;
      S_T1: {Read, MDRin} = 2'b11;
      S_T2: {MDRout, IRin} = 2'b11;
      S_T3: begin
        if (op_alu || op_imm)    {Grb, Rout, Yin} = 3'b111;
        else if (op_addr)        {Grb, BAout, Yin} = 3'b111;
        else if (ir_op == OP_BR) {Gra, Rout, CONin} = 3'b111;
        else if (ir_op == OP_JR) {Gra, Rout, PCin} = 3'b111;
        else if (ir_op == OP_IN) {InPortout, Gra, Rin} = 3'b111;
        else if (ir_op == OP_OUT) {Gra, Rout, OutPortIn} = 3'b111;
        err_illegal = !legal;
      end
      S_T4: begin
        if (op_alu)              {Grc, Rout, ZLowIn} = 3'b111;
        else if (op_imm || op_addr) {RCout, ZLowIn} = 2'b11;
        else if (ir_op == OP_BR) {PCout, Yin} = 2'b11;
        if (op_alu || op_imm) begin
          case (ir_op)
            OP_SUB:          alu_op = 4'b0001;
            OP_AND, OP_ANDI: alu_op = 4'b0010;
            OP_OR, OP_ORI:   alu_op = 4'b0011;
            default:         alu_op = 4'b0000;
          endcase
        end
      end
      S_T5: begin
        if (op_alu || op_imm || ir_op == OP_LDI) {ZLowOut, Gra, Rin} = 3'b111;
        else if (ir_op inside {OP_LD, OP_ST})    {ZLowOut, MARin} = 2'b11;
        else if (ir_op == OP_BR)                 {RCout, ZLowIn} = 2'b11;
      end
      S_T6: begin
        if (ir_op == OP_LD)      {Read, MDRin} = 2'b11;
        else if (ir_op == OP_ST) {Gra, Rout, MDRin} = 3'b111;
        else if (ir_op == OP_BR && con_ff) {ZLowOut, PCin} = 2'b11;
      end
      S_T7: begin
        if (ir_op == OP_LD)      {MDRout, Gra, Rin} = 3'b111;
        else if (ir_op == OP_ST) Write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
